podule_decode: RTL and testbench

PODULE_DECODE -- requirements
Module: podule_decode

---
 rtl/podule_decode.sv | 180 ++++++++++++++++++
 tb/tb_podule_decode.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/podule_decode.sv
// ---------------------------------------------------------------------------
// podule_decode
//
// Address decoder and wait-state sequencer for a podule-style expansion bus.
// When a bus cycle starts, the word address is decoded into either the ROM
// select or one of NSLOT one-hot I/O slot selects. The access is then held
// for a programmable number of wait states and completed with a single-cycle
// rdy pulse. An optional flash page latch lives at slot PAGE_SLOT.
//
// Optional feature macro:
//   PODULE_DECODE_PAGE_LATCH_EN - when defined, a completed write cycle to
//   slot PAGE_SLOT loads 'page' from the latched write data. When undefined,
//   'page' is tied to zero and PAGE_SLOT is an ordinary slot.
//
// Ports:
//   clk      - system clock, all state changes on its rising edge
//   rst_n    - asynchronous active-low reset
//   a        - bus word address
//   strb     - bus cycle request, level-sensitive, held until cycle end
//   we       - write cycle when high
//   d        - write data for the page latch
//   ws_rom   - wait states for ROM accesses
//   ws_slot  - packed per-slot wait states, slot k at [k*WS_W +: WS_W]
//   rom_cs   - ROM select
//   slot_cs  - one-hot I/O slot select
//   rdy      - one-cycle cycle-complete pulse
//   busy     - high whenever the sequencer is not idle
//   page     - flash page latch contents
// ---------------------------------------------------------------------------
module podule_decode #(
    parameter int ADDR_W    = 12,
    parameter int NSLOT     = 8,
    parameter int WS_W      = 4,
    parameter int PAGE_W    = 8,
    parameter int PAGE_SLOT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      a,
    input  logic                   strb,
    input  logic                   we,
    input  logic [PAGE_W-1:0]      d,
    input  logic [WS_W-1:0]        ws_rom,
    input  logic [NSLOT*WS_W-1:0]  ws_slot,
    output logic                   rom_cs,
    output logic [NSLOT-1:0]       slot_cs,
    output logic                   rdy,
    output logic                   busy,
    output logic [PAGE_W-1:0]      page
);

    localparam int SEL_W = $clog2(NSLOT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } state_t;

    state_t          state;
    logic [WS_W-1:0] cnt;

    logic             is_slot;
    logic [SEL_W-1:0] slot_idx;
    logic [WS_W-1:0]  ws_sel;
    logic [NSLOT-1:0] slot_dec;

    // Decode of the live address. It is only consumed on the IDLE->ACCESS
    // edge, so later changes on a or the wait-state inputs cannot disturb
    // an access in progress.
    always_comb begin
        is_slot  = a[ADDR_W-1];
        slot_idx = a[ADDR_W-2 -: SEL_W];
        ws_sel   = is_slot ? ws_slot[int'(slot_idx)*WS_W +: WS_W] : ws_rom;
        slot_dec = '0;
        if (is_slot) begin
            slot_dec[slot_idx] = 1'b1;
        end
    end

    // Address bits below the slot index do not take part in decoding.
    logic unused_addr;
    assign unused_addr = &{1'b0, a[ADDR_W-2-SEL_W:0]};

    // Main sequencer. rdy is registered and is high exactly while the
    // ACCESS counter sits at zero: it is set on the edge that loads or
    // decrements the counter to zero, and cleared on the edge that leaves
    // ACCESS. An abort clears the counter so it never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rom_cs  <= 1'b0;
            slot_cs <= '0;
            rdy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (strb) begin
                        state   <= ACCESS;
                        cnt     <= ws_sel;
                        rom_cs  <= !is_slot;
                        slot_cs <= slot_dec;
                        rdy     <= (ws_sel == '0);
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // rdy has been presented, so the access completes
                        rdy <= 1'b0;
                        if (strb) begin
                            state <= HOLD;
                        end else begin
                            state   <= IDLE;
                            rom_cs  <= 1'b0;
                            slot_cs <= '0;
                        end
                    end else if (!strb) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        rom_cs  <= 1'b0;
                        slot_cs <= '0;
                        rdy     <= 1'b0;
                    end else begin
                        cnt <= cnt - WS_W'(1);
                        rdy <= (cnt == WS_W'(1));
                    end
                end
                HOLD: begin
                    if (!strb) begin
                        state   <= IDLE;
                        rom_cs  <= 1'b0;
                        slot_cs <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rom_cs  <= 1'b0;
                    slot_cs <= '0;
                    rdy     <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef PODULE_DECODE_PAGE_LATCH_EN
    logic              we_q;
    logic [PAGE_W-1:0] d_q;
    logic [PAGE_W-1:0] page_q;

    // we and d are captured with the address; the page loads on the edge
    // that ends the rdy cycle of a write to the page slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            d_q    <= '0;
            page_q <= '0;
        end else begin
            if (state == IDLE && strb) begin
                we_q <= we;
                d_q  <= d;
            end
            if (state == ACCESS && rdy && we_q && slot_cs[PAGE_SLOT]) begin
                page_q <= d_q;
            end
        end
    end

    assign page = page_q;
`else
    assign page = '0;

    logic unused_page;
    assign unused_page = &{1'b0, we, d, slot_cs[PAGE_SLOT]};
`endif

endmodule

// File: tb/tb_podule_decode.sv
// ---------------------------------------------------------------------------
// tb_podule_decode
//
// Scoreboard bench for podule_decode at default parameters. Each access
// pushes its expected selects and rdy cycle into a queue; a monitor pops
// and compares whenever rdy is seen. Directed checks cover reset, hold,
// abort, mid-access reset and input changes after latching.
// ---------------------------------------------------------------------------
module tb_podule_decode;

    logic        clk;
    logic        rst_n;
    logic [11:0] a;
    logic        strb;
    logic        we;
    logic [7:0]  d;
    logic [3:0]  ws_rom;
    logic [31:0] ws_slot;
    logic        rom_cs;
    logic [7:0]  slot_cs;
    logic        rdy;
    logic        busy;
    logic [7:0]  page;

    podule_decode dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .strb    (strb),
        .we      (we),
        .d       (d),
        .ws_rom  (ws_rom),
        .ws_slot (ws_slot),
        .rom_cs  (rom_cs),
        .slot_cs (slot_cs),
        .rdy     (rdy),
        .busy    (busy),
        .page    (page)
    );

    typedef struct {
        logic       rom;
        logic [7:0] slot;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] page_exp = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Monitor: every rdy pulse must match the oldest outstanding access.
    always @(negedge clk) begin
        if (rst_n && rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_rdy: got rdy=1 expected no pending access (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rdy_cycle", cyc, e.cyc);
                checkOutput("rdy_rom_cs", {31'b0, rom_cs}, {31'b0, e.rom});
                checkOutput("rdy_slot_cs", {24'b0, slot_cs}, {24'b0, e.slot});
            end
        end
    end

    // Waits for rdy, drops strb in HOLD and checks the return to idle.
    task automatic finishAccess(input logic exp_rom, input logic [7:0] exp_slot);
        int n;
        n = 0;
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rdy_seen", {31'b0, rdy}, 32'd1);
        @(negedge clk);
        checkOutput("hold_rdy_low", {31'b0, rdy}, 32'd0);
        checkOutput("hold_slot_cs", {24'b0, slot_cs}, {24'b0, exp_slot});
        checkOutput("hold_rom_cs", {31'b0, rom_cs}, {31'b0, exp_rom});
        strb = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("idle_sel", {23'b0, rom_cs, slot_cs}, 32'd0);
        checkOutput("page", {24'b0, page}, {24'b0, page_exp});
    endtask

    // Starts one access, checks the first ACCESS cycle and completes it.
    // With perturb set, address, data and wait states are scrambled after
    // latching; the access must still behave as originally requested.
    task automatic applyStimulus(input logic [11:0] addr, input logic wr,
                                 input logic [7:0] dat, input logic [3:0] wsr,
                                 input logic [31:0] wss, input logic exp_rom,
                                 input logic [7:0] exp_slot, input int exp_ws,
                                 input logic perturb);
        exp_t e;
        @(negedge clk);
        a       = addr;
        we      = wr;
        d       = dat;
        ws_rom  = wsr;
        ws_slot = wss;
        strb    = 1'b1;
        e.rom   = exp_rom;
        e.slot  = exp_slot;
        e.cyc   = cyc + 1 + exp_ws;
        sb.push_back(e);
`ifdef PODULE_DECODE_PAGE_LATCH_EN
        if (wr && exp_slot == 8'h10) page_exp = dat;
`endif
        @(negedge clk);
        checkOutput("first_rom_cs", {31'b0, rom_cs}, {31'b0, exp_rom});
        checkOutput("first_slot_cs", {24'b0, slot_cs}, {24'b0, exp_slot});
        checkOutput("first_busy", {31'b0, busy}, 32'd1);
        if (perturb) begin
            a       = 12'h000;
            ws_rom  = 4'hF;
            ws_slot = 32'hFFFF_FFFF;
            we      = ~wr;
            d       = ~dat;
        end
        finishAccess(exp_rom, exp_slot);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        logic saw_rdy;
        rst_n   = 1'b0;
        strb    = 1'b0;
        a       = 12'h000;
        we      = 1'b0;
        d       = 8'h00;
        ws_rom  = 4'h0;
        ws_slot = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rom_cs", {31'b0, rom_cs}, 32'd0);
        checkOutput("reset_slot_cs", {24'b0, slot_cs}, 32'd0);
        checkOutput("reset_rdy", {31'b0, rdy}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_page", {24'b0, page}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] ROM read, two wait states");
        applyStimulus(12'h010, 1'b0, 8'h00, 4'd2, 32'h0, 1'b1, 8'h00, 2, 1'b0);

        $display("[TB] slot sweep, zero wait states");
        applyStimulus(12'h800, 1'b0, 8'h00, 4'd9, 32'h0, 1'b0, 8'h01, 0, 1'b0);
        applyStimulus(12'h900, 1'b0, 8'h00, 4'd9, 32'h0, 1'b0, 8'h02, 0, 1'b0);
        applyStimulus(12'hA00, 1'b0, 8'h00, 4'd9, 32'h0, 1'b0, 8'h04, 0, 1'b0);
        applyStimulus(12'hB00, 1'b0, 8'h00, 4'd9, 32'h0, 1'b0, 8'h08, 0, 1'b0);
        applyStimulus(12'hC00, 1'b0, 8'h00, 4'd9, 32'h0, 1'b0, 8'h10, 0, 1'b0);

        $display("[TB] page slot write then read");
        applyStimulus(12'hC00, 1'b1, 8'hA5, 4'd0, 32'h0001_0000, 1'b0, 8'h10, 1, 1'b0);
        applyStimulus(12'hC00, 1'b0, 8'h3C, 4'd0, 32'h0001_0000, 1'b0, 8'h10, 1, 1'b0);

        $display("[TB] ROM read, fifteen wait states");
        applyStimulus(12'h3FF, 1'b0, 8'h00, 4'd15, 32'h0, 1'b1, 8'h00, 15, 1'b0);

        $display("[TB] abort after three ACCESS cycles");
        @(negedge clk);
        a       = 12'h900;
        ws_slot = 32'h0000_0070;
        we      = 1'b1;
        d       = 8'h77;
        strb    = 1'b1;
        saw_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_rdy = saw_rdy | rdy;
        end
        checkOutput("abort_slot_cs", {24'b0, slot_cs}, 32'h02);
        strb = 1'b0;
        @(negedge clk);
        saw_rdy = saw_rdy | rdy;
        checkOutput("abort_no_rdy", {31'b0, saw_rdy}, 32'd0);
        checkOutput("abort_sel", {23'b0, rom_cs, slot_cs}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_page", {24'b0, page}, {24'b0, page_exp});
        applyStimulus(12'h900, 1'b0, 8'h00, 4'd0, 32'h0000_0030, 1'b0, 8'h02, 3, 1'b0);

        $display("[TB] inputs changed after latching");
        applyStimulus(12'hA00, 1'b0, 8'h00, 4'd0, 32'h0000_0300, 1'b0, 8'h04, 3, 1'b1);

        $display("[TB] reset in the middle of an access");
        @(negedge clk);
        a       = 12'hB00;
        ws_slot = 32'h0000_5000;
        we      = 1'b0;
        strb    = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_slot_cs", {24'b0, slot_cs}, 32'h08);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_sel", {23'b0, rom_cs, slot_cs}, 32'd0);
        checkOutput("async_reset_rdy", {31'b0, rdy}, 32'd0);
        checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_reset_page", {24'b0, page}, 32'd0);
        page_exp = 8'h00;
        @(negedge clk);
        rst_n  = 1'b1;
        e.rom  = 1'b0;
        e.slot = 8'h08;
        e.cyc  = cyc + 1 + 5;
        sb.push_back(e);
        finishAccess(1'b0, 8'h08);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
